// File: rtl/led_code_blinker.sv
// led_code_blinker: blinks the LED `code` times, then holds a dark gap, paced by a tick strobe.
// Define LED_CODE_INT_TICK_EN to derive the tick from an internal TICK_DIV divider instead of tick_in.
module led_code_blinker #(
   parameter int TICK_DIV  = 20000000,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 2,
   parameter int GAP_TICKS = 8,
   parameter int CODE_W    = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tick_in,
   input  logic [CODE_W-1:0] code,
   output logic              led,
   output logic              busy,
   output logic              seq_done
);
   localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                                                 : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
   localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] blinks_q, blinks_d, code_q, code_d;
   logic              led_q, led_d, done_q, done_d;
   logic              tick, last_hit;
   logic [CNT_W-1:0]  last;

`ifdef LED_CODE_INT_TICK_EN
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   logic [DIV_W-1:0] div_q, div_d;
   assign tick = (div_q == DIV_W'(TICK_DIV - 1));
   always_comb div_d = tick ? '0 : div_q + 1'b1;
   always_ff @(posedge clock) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end
`else
   assign tick = tick_in;
`endif

   assign last     = (state_q == ON) ? ON_LAST : (state_q == OFF) ? OFF_LAST : GAP_LAST;
   assign last_hit = (cnt_q == last);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      blinks_d = blinks_q;
      code_d   = code_q;
      done_d   = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: if (code != '0) begin
               code_d   = code;
               blinks_d = '0;
               cnt_d    = '0;
               state_d  = ON;
            end
            default: begin
               cnt_d = last_hit ? '0 : cnt_q + 1'b1;
               if (last_hit) begin
                  // the final blink of a sequence leads into the long gap instead of a short off
                  if (state_q == ON) state_d = (blinks_q == code_q - 1'b1) ? GAP : OFF;
                  if (state_q == OFF) begin
                     state_d  = ON;
                     blinks_d = blinks_q + 1'b1;
                  end
                  if (state_q == GAP) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         endcase
      end
      led_d = (state_d == ON);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         blinks_q <= '0;
         code_q   <= '0;
         led_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         blinks_q <= blinks_d;
         code_q   <= code_d;
         led_q    <= led_d;
         done_q   <= done_d;
      end
   end

   assign led      = led_q;
   assign busy     = (state_q != IDLE);
   assign seq_done = done_q;
endmodule

// File: tb/tb_led_code_blinker.sv
// tb_led_code_blinker: directed checks of blink patterns, code latching, slow ticks and reset.
module tb_led_code_blinker;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick_in = 1'b1;
   logic [3:0] code = 4'd3;
   logic       led, busy, seq_done;
   logic [2:0] exp_v;
   int         errors = 0;
   int         checks = 0;

   led_code_blinker dut (
      .clock(clock), .reset(reset), .tick_in(tick_in), .code(code),
      .led(led), .busy(busy), .seq_done(seq_done)
   );

   always #5 clock = ~clock;

   // expected {led, busy, seq_done} for cycle rel of a code=3 sequence with a tick every cycle
   function automatic logic [2:0] code3_exp(input int rel);
      return {rel < 10 && rel % 4 < 2, rel < 18, rel == 18};
   endfunction

   task automatic test_reset();
      reset = 1'b1; tick_in = 1'b1; code = 4'd3;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({led, busy, seq_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset: got %b want 000", {led, busy, seq_done});
      end
   endtask

   task automatic test_code3();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         exp_v = code3_exp(i);
         checks++;
         if ({led, busy, seq_done} !== exp_v) begin
            errors++;
            $display("FAIL code3 cycle %0d: got %b want %b", i, {led, busy, seq_done}, exp_v);
         end
         if (i == 0) code = 4'd0;
      end
   endtask

   task automatic test_code0();
      code = 4'd0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         checks++;
         if ({led, busy, seq_done} !== 3'b000) begin
            errors++;
            $display("FAIL code0 cycle %0d: got %b want 000", i, {led, busy, seq_done});
         end
      end
   endtask

   task automatic test_code1_change();
      code = 4'd1;
      for (int i = 0; i < 38; i++) begin
         @(posedge clock); #1;
         exp_v = {(i < 2) || (i >= 11 && i < 29 && (i - 11) % 4 < 2),
                  (i < 10) || (i >= 11 && i < 37), i == 10 || i == 37};
         checks++;
         if ({led, busy, seq_done} !== exp_v) begin
            errors++;
            $display("FAIL code1_change cycle %0d: got %b want %b", i, {led, busy, seq_done}, exp_v);
         end
         if (i == 5) code = 4'd5;
         if (i == 12) code = 4'd0;
      end
   endtask

   task automatic test_slow_tick();
      code = 4'd2; tick_in = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         exp_v = {(i < 8) || (i >= 16 && i < 24), i < 56, i == 56};
         checks++;
         if ({led, busy, seq_done} !== exp_v) begin
            errors++;
            $display("FAIL slow_tick cycle %0d: got %b want %b", i, {led, busy, seq_done}, exp_v);
         end
         if (i == 0) code = 4'd0;
         tick_in = ((i + 1) % 4 == 0);
      end
      tick_in = 1'b1;
   endtask

   task automatic test_reset_mid();
      code = 4'd3;
      for (int i = 0; i < 26; i++) begin
         @(posedge clock); #1;
         exp_v = (i < 5) ? code3_exp(i) : (i == 5) ? 3'b000 : code3_exp(i - 6);
         checks++;
         if ({led, busy, seq_done} !== exp_v) begin
            errors++;
            $display("FAIL reset_mid cycle %0d: got %b want %b", i, {led, busy, seq_done}, exp_v);
         end
         if (i == 4) reset = 1'b1;
         if (i == 5) reset = 1'b0;
         if (i == 6) code = 4'd0;
      end
   endtask

   task automatic test_back_to_back();
      code = 4'd2;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         exp_v = {(i % 15) < 6 && (i % 15) % 4 < 2, (i % 15) < 14, (i % 15) == 14};
         checks++;
         if ({led, busy, seq_done} !== exp_v) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %b want %b", i, {led, busy, seq_done}, exp_v);
         end
         if (i == 28) code = 4'd0;
      end
   endtask

   initial begin
      test_reset();
      test_code3();
      test_code0();
      test_code1_change();
      test_slow_tick();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/led_code_blinker.md
LED_CODE_BLINKER -- requirements
Module: led_code_blinker

Interface
REQ-001 SHALL have parameter TICK_DIV, default 20000000, clock cycles per tick when the internal tick is compiled in.
REQ-002 SHALL have parameter ON_TICKS, default 2, ticks the LED is lit per blink.
REQ-003 SHALL have parameter OFF_TICKS, default 2, ticks the LED is dark between blinks.
REQ-004 SHALL have parameter GAP_TICKS, default 8, ticks the LED is dark after the last blink of a sequence.
REQ-005 SHALL have parameter CODE_W, default 4, width of the status code.
REQ-006 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port tick_in  input  1  one-cycle timing strobe from the upstream blink divider.
REQ-009 SHALL have port code  input  CODE_W  status code (number of blinks) to display.
REQ-010 SHALL have port led  output  1  registered LED drive, high = lit.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port seq_done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-013 SHALL implement FSM states IDLE, ON, OFF, GAP; led SHALL be high only in ON.
REQ-014 SHALL advance timing only on cycles with an active tick; non-tick cycles SHALL hold state and counters.
REQ-015 In IDLE on a tick: code != 0 -> latch code into code_q, clear blink count and tick count, go to ON; code == 0 -> stay IDLE, led low.
REQ-016 Each state SHALL count ticks from 0; on a tick with count == limit-1 it SHALL transition and clear the count, otherwise increment it.
REQ-017 ON expiry: if blinks completed == code_q-1 -> GAP, else -> OFF; OFF expiry -> ON and increment blinks completed.
REQ-018 GAP expiry -> IDLE with seq_done high for exactly that following cycle.
REQ-019 Changes on code during a sequence SHALL be ignored; the new value SHALL take effect only at the next IDLE tick.
REQ-020 Tick counter width SHALL be $clog2 of the largest of ON_TICKS, OFF_TICKS, GAP_TICKS, minimum 1; blink counter width CODE_W; no wrap SHALL occur for any code up to 2^CODE_W-1.
REQ-021 A tick arriving in the same cycle as reset SHALL be ignored.

Reset
REQ-022 Reset SHALL force state IDLE, led 0, busy 0, seq_done 0, and all counters and code_q to 0 on the next edge, including mid-sequence.

Configuration
REQ-023 With macro LED_CODE_INT_TICK_EN defined, an internal divider SHALL pulse a tick for one cycle every TICK_DIV cycles (counter cleared by reset), and tick_in SHALL be ignored.
REQ-024 Without LED_CODE_INT_TICK_EN, tick_in SHALL be the only tick source and no divider logic SHALL be present.

Verification (macro undefined, defaults, tick_in held high unless stated)
REQ-025 Reset released, code=3 -> led 1 for 2 cycles, 0 for 2, 1 for 2, 0 for 2, 1 for 2, 0 for 8; seq_done pulses once; busy high for 18 cycles.
REQ-026 code=0 for 50 cycles -> led 0, busy 0, seq_done never asserted.
REQ-027 code=1 -> single 2-cycle led high, then 8 low, seq_done; code changed to 5 mid-GAP -> next sequence shows 5 blinks.
REQ-028 tick_in pulsed every 4th cycle, code=2 -> each led level lasts 4x its tick count (8 high, 8 low, 8 high, 32 low).
REQ-029 reset asserted during second ON of code=3 -> led 0, busy 0 next cycle; next sequence restarts from first blink.
REQ-030 Macro defined, TICK_DIV=5, tick_in tied low, code=1 -> led high 10 cycles, then low 40 cycles, seq_done once.
